// File: rtl/regfile32_dec_pkg.sv
// Shared constants for the 32-entry register file and its write-address decoder.
package regfile32_dec_pkg;

    localparam int REG_CNT    = 32;
    localparam int REG_IDX_W  = 5;
    localparam int DATA_W_DEF = 32;

    localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd0;

endpackage : regfile32_dec_pkg

// File: rtl/regfile32_dec_decoder5_32.sv
// 5-to-32 one-hot decoder with active-high enable; all-zero output when disabled.
module decoder5_32
    import regfile32_dec_pkg::*;
(
    input  logic [REG_IDX_W-1:0] i_idx,
    input  logic                 i_en,
    output logic [REG_CNT-1:0]   o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_idx] = 1'b1;
        end
    end

endmodule : decoder5_32

// File: rtl/regfile32_dec.sv
// 32-entry register file: two combinational read ports, one synchronous write port
// driven by a gated one-hot write-enable vector, optional hardwired-zero r0 and bypass.
module regfile32_dec
    import regfile32_dec_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter bit R0_ZERO = 1'b1,
    parameter bit BYPASS  = 1'b0
) (
    input  logic                 iClk,
    input  logic                 iRst_n,
    input  logic                 iWe,
    input  logic [REG_IDX_W-1:0] iWaddr,
    input  logic [DATA_W-1:0]    iWdata,
    input  logic [REG_IDX_W-1:0] iRaddr1,
    input  logic [REG_IDX_W-1:0] iRaddr2,
    output logic [DATA_W-1:0]    oRdata1,
    output logic [DATA_W-1:0]    oRdata2,
    output logic [REG_CNT-1:0]   oWeVec
);

    logic [DATA_W-1:0]  r_regs [REG_CNT];
    logic [REG_CNT-1:0] w_raw_onehot;
    logic [REG_CNT-1:0] w_we_vec;
    logic               w_wr_live;
    logic               w_hit1;
    logic               w_hit2;
    logic [DATA_W-1:0]  w_rdata1;
    logic [DATA_W-1:0]  w_rdata2;

    decoder5_32 u_wdec (
        .i_idx    (iWaddr),
        .i_en     (iWe),
        .o_onehot (w_raw_onehot)
    );

    assign w_wr_live = iWe & iRst_n;

    // The decoder output is not trusted when disabled, so gate it here as well.
    always_comb begin
        w_we_vec = w_raw_onehot & {REG_CNT{w_wr_live}};
        if (R0_ZERO) begin
            w_we_vec[ZERO_REG] = 1'b0;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            for (int i = 0; i < REG_CNT; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REG_CNT; i++) begin
                if (w_we_vec[i]) begin
                    r_regs[i] <= iWdata;
                end
            end
        end
    end

    assign w_hit1 = w_wr_live && (iRaddr1 == iWaddr);
    assign w_hit2 = w_wr_live && (iRaddr2 == iWaddr);

    // Priority: reset and forced-zero r0 override bypass, bypass overrides storage.
    always_comb begin
        w_rdata1 = r_regs[iRaddr1];
        if (BYPASS && w_hit1) begin
            w_rdata1 = iWdata;
        end
        if (!iRst_n || (R0_ZERO && (iRaddr1 == ZERO_REG))) begin
            w_rdata1 = '0;
        end
    end

    always_comb begin
        w_rdata2 = r_regs[iRaddr2];
        if (BYPASS && w_hit2) begin
            w_rdata2 = iWdata;
        end
        if (!iRst_n || (R0_ZERO && (iRaddr2 == ZERO_REG))) begin
            w_rdata2 = '0;
        end
    end

    assign oRdata1 = w_rdata1;
    assign oRdata2 = w_rdata2;
    assign oWeVec  = w_we_vec;

endmodule : regfile32_dec

// File: tb/tb_regfile32_dec.sv
// Bench for regfile32_dec: three parameter variants share one stimulus stream and are
// checked every cycle against an array model, plus directed literal expectations.
module tb_regfile32_dec;

    localparam int NV = 3;

    logic        iClk;
    logic        iRst_n;
    logic        iWe;
    logic [4:0]  iWaddr;
    logic [31:0] iWdata;
    logic [4:0]  iRaddr1;
    logic [4:0]  iRaddr2;
    logic [31:0] rd1 [NV];
    logic [31:0] rd2 [NV];
    logic [31:0] wv  [NV];

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_regs [NV][32];
    logic [31:0] exp_q[$];

    // variant 0: r0 zero, no bypass; 1: r0 zero, bypass; 2: r0 ordinary storage, no bypass
    regfile32_dec #(.DATA_W(32), .R0_ZERO(1'b1), .BYPASS(1'b0)) u_dut0 (
        .iClk(iClk), .iRst_n(iRst_n), .iWe(iWe), .iWaddr(iWaddr), .iWdata(iWdata),
        .iRaddr1(iRaddr1), .iRaddr2(iRaddr2), .oRdata1(rd1[0]), .oRdata2(rd2[0]), .oWeVec(wv[0]));
    regfile32_dec #(.DATA_W(32), .R0_ZERO(1'b1), .BYPASS(1'b1)) u_dut1 (
        .iClk(iClk), .iRst_n(iRst_n), .iWe(iWe), .iWaddr(iWaddr), .iWdata(iWdata),
        .iRaddr1(iRaddr1), .iRaddr2(iRaddr2), .oRdata1(rd1[1]), .oRdata2(rd2[1]), .oWeVec(wv[1]));
    regfile32_dec #(.DATA_W(32), .R0_ZERO(1'b0), .BYPASS(1'b0)) u_dut2 (
        .iClk(iClk), .iRst_n(iRst_n), .iWe(iWe), .iWaddr(iWaddr), .iWdata(iWdata),
        .iRaddr1(iRaddr1), .iRaddr2(iRaddr2), .oRdata1(rd1[2]), .oRdata2(rd2[2]), .oWeVec(wv[2]));

    // clock / reset
    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    function automatic bit r0_of(int k);
        return (k != 2);
    endfunction

    function automatic bit byp_of(int k);
        return (k == 1);
    endfunction

    function automatic bit write_takes(int k);
        return iRst_n && iWe && !(r0_of(k) && iWaddr == 5'd0);
    endfunction

    function automatic logic [31:0] m_read(int k, logic [4:0] a);
        if (!iRst_n) return 32'h0;
        if (r0_of(k) && a == 5'd0) return 32'h0;
        if (byp_of(k) && iWe && a == iWaddr) return iWdata;
        return m_regs[k][a];
    endfunction

    function automatic logic [31:0] m_wevec(int k);
        logic [31:0] v;
        v = 32'h0;
        if (write_takes(k)) v = 32'h1 << iWaddr;
        return v;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NV; k++)
            for (int r = 0; r < 32; r++)
                m_regs[k][r] = 32'h0;
    endtask

    always @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            model_clear();
        end else begin
            for (int k = 0; k < NV; k++)
                if (write_takes(k)) m_regs[k][iWaddr] = iWdata;
        end
    end

    task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[v%0d] t=%0t actual=%h expected=%h", name, k, $time, act, exp);
        end
    endtask

    // compare process
    always @(negedge iClk) begin
        if (chk_en) begin
            for (int k = 0; k < NV; k++) begin
                chk("model_rd1", k, rd1[k], m_read(k, iRaddr1));
                chk("model_rd2", k, rd2[k], m_read(k, iRaddr2));
                chk("model_wevec", k, wv[k], m_wevec(k));
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic drive(logic we, logic [4:0] wa, logic [31:0] wd, logic [4:0] ra1, logic [4:0] ra2);
        iWe = we; iWaddr = wa; iWdata = wd; iRaddr1 = ra1; iRaddr2 = ra2;
    endtask

    task automatic write_reg(logic [4:0] wa, logic [31:0] wd);
        drive(1'b1, wa, wd, 5'd0, 5'd0);
        tick();
    endtask

    initial begin
        model_clear();
        iRst_n = 1'b0;
        drive(1'b1, 5'd9, 32'h1234, 5'd9, 5'd9);
        #2;
        for (int k = 0; k < NV; k++) begin
            chk("reset_rd1", k, rd1[k], 32'h0);
            chk("reset_wevec", k, wv[k], 32'h0);
        end
        tick();
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
        iRst_n = 1'b1;
        chk_en = 1'b1;
        #1;
        chk("reset_write_discarded", 0, rd1[0], 32'h0);
        tick();

        // basic write/read
        drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd6);
        #1;
        chk("basic_wevec", 0, wv[0], 32'h0000_0020);
        chk("basic_old", 0, rd1[0], 32'h0);
        tick();
        drive(1'b0, 5'd5, 32'h0, 5'd5, 5'd6);
        #1;
        chk("basic_rd1", 0, rd1[0], 32'hDEADBEEF);
        chk("basic_rd2", 0, rd2[0], 32'h0);
        tick();

        // register 0
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        #1;
        chk("r0_wevec", 0, wv[0], 32'h0);
        chk("r0_wevec_byp", 1, wv[1], 32'h0);
        chk("r0_rd_byp", 1, rd1[1], 32'h0);
        chk("r0_store_wevec", 2, wv[2], 32'h0000_0001);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        #1;
        chk("r0_after", 0, rd1[0], 32'h0);
        chk("r0_after_byp", 1, rd2[1], 32'h0);
        chk("r0_store_after", 2, rd1[2], 32'hFFFFFFFF);
        tick();

        // disabled write
        write_reg(5'd3, 32'h11);
        for (int n = 0; n < 3; n++) begin
            drive(1'b0, 5'd3, 32'h22, 5'd3, 5'd3);
            #1;
            chk("dis_wevec", 0, wv[0], 32'h0);
            chk("dis_rd", 0, rd1[0], 32'h11);
            tick();
        end
        drive(1'b0, 5'd3, 32'h22, 5'd3, 5'd3);
        #1;
        chk("dis_final", 0, rd1[0], 32'h11);

        // same-cycle read/write at reg 31
        write_reg(5'd31, 32'hA);
        drive(1'b1, 5'd31, 32'hB, 5'd31, 5'd31);
        #1;
        chk("rw_nobyp", 0, rd1[0], 32'hA);
        chk("rw_byp1", 1, rd1[1], 32'hB);
        chk("rw_byp2", 1, rd2[1], 32'hB);
        tick();
        drive(1'b0, 5'd31, 32'h0, 5'd31, 5'd31);
        #1;
        chk("rw_next", 0, rd1[0], 32'hB);
        tick();

        // sweep: write i*0x01010101 to regs 1..31, read back both ports
        for (int i = 1; i < 32; i++) begin
            write_reg(5'(i), 32'h0101_0101 * 32'(i));
            exp_q.push_back(32'h0101_0101 * 32'(i));
        end
        for (int i = 1; i < 32; i++) begin
            logic [31:0] e;
            drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(i));
            #1;
            e = exp_q.pop_front();
            chk("sweep_rd1", 0, rd1[0], e);
            chk("sweep_rd2", 0, rd2[0], e);
            chk("sweep_rd1", 1, rd1[1], e);
            tick();
        end

        // async reset mid-cycle with nonzero contents, no clock edge
        drive(1'b0, 5'd0, 32'h0, 5'd17, 5'd31);
        #2;
        iRst_n = 1'b0;
        #1;
        chk("async_rd1", 0, rd1[0], 32'h0);
        chk("async_rd2", 0, rd2[0], 32'h0);
        chk("async_wevec", 0, wv[0], 32'h0);
        tick();
        iRst_n = 1'b1;
        tick();

        // reset pulsed during a write to reg 7
        write_reg(5'd7, 32'h77);
        write_reg(5'd8, 32'h88);
        drive(1'b1, 5'd7, 32'hCAFE_F00D, 5'd7, 5'd8);
        #2;
        iRst_n = 1'b0;
        tick();
        drive(1'b0, 5'd7, 32'h0, 5'd7, 5'd8);
        iRst_n = 1'b1;
        #1;
        chk("rstwr_r7", 0, rd1[0], 32'h0);
        chk("rstwr_r8", 0, rd2[0], 32'h0);
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
            #1;
            chk("rstwr_all1", 2, rd1[2], 32'h0);
            chk("rstwr_all2", 2, rd2[2], 32'h0);
            tick();
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_regfile32_dec
